// File: rtl/logic_op_pipe_if.sv
// Operand/result bus for logic_op_pipe: input beat channel and output result channel.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid && ready;
// the source holds its payload stable while valid && !ready, and ready never depends
// combinationally on valid.
interface logic_op_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_red;

  modport master (
    output in_valid, in_a, in_b, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_red
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_last, out_ready,
    output in_ready, out_valid, out_y, out_red
  );
endinterface

// File: rtl/logic_op_pipe.sv
// Registered bitwise logic unit with accumulate modes and a DEPTH-entry result FIFO.
// Define LOGIC_OP_PIPE_STATS_EN to add the saturating 16-bit popped-result counter out_count.
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  logic_op_pipe_if.slave  bus,
  output logic            busy
`ifdef LOGIC_OP_PIPE_STATS_EN
  ,
  output logic [15:0]     out_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic             acc_or;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_y;

  logic             full;
  logic             accept;
  logic             pop;
  logic             push;
  logic             use_or;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] push_data;

  // in_ready comes only from the registered count, so there is no path from out_ready.
  assign full         = (count == CW'(DEPTH));
  assign bus.in_ready = !full;
  assign accept       = bus.in_valid && !full;
  assign bus.out_valid = (count != '0);
  assign pop          = bus.out_valid && bus.out_ready;

  // Mid-sequence the latched op selects the term; in_op is only honoured while IDLE.
  assign use_or = (state == ACCUM) ? acc_or : bus.in_op[0];
  assign term   = use_or ? (bus.in_a | bus.in_b) : (bus.in_a & bus.in_b);
  assign fold   = acc_or ? (acc | term) : (acc & term);

  always_comb begin
    push      = 1'b0;
    push_data = term;
    if (state == ACCUM) begin
      push      = accept && bus.in_last;
      push_data = fold;
    end else begin
      push = accept && ((bus.in_op[2:1] != 2'b11) || bus.in_last);
      case (bus.in_op)
        3'd0:    push_data = bus.in_a & bus.in_b;
        3'd1:    push_data = bus.in_a | bus.in_b;
        3'd2:    push_data = bus.in_a ^ bus.in_b;
        3'd3:    push_data = ~(bus.in_a & bus.in_b);
        3'd4:    push_data = ~(bus.in_a | bus.in_b);
        3'd5:    push_data = ~(bus.in_a ^ bus.in_b);
        default: push_data = term;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc_or <= 1'b0;
      acc    <= '0;
    end else if (accept) begin
      if (state == ACCUM) begin
        if (bus.in_last) state <= IDLE;
        else             acc   <= fold;
      end else if ((bus.in_op[2:1] == 2'b11) && !bus.in_last) begin
        state  <= ACCUM;
        acc_or <= bus.in_op[0];
        acc    <= term;
      end
    end
  end

  assign busy = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_y <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_y <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // When empty, the most recently popped value stays on out_y.
  assign bus.out_y   = bus.out_valid ? mem[rd_ptr] : last_y;
  assign bus.out_red = &bus.out_y;

`ifdef LOGIC_OP_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           out_count <= '0;
    else if (pop && (out_count != 16'hFFFF)) out_count <= out_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe (WIDTH=8, DEPTH=2): directed cases plus random traffic
// scored against a sequence-level reference model.
module tb_logic_op_pipe;
  localparam int W = 8;
  localparam int D = 2;

  logic clk;
  logic rst_n;
  logic busy;
`ifdef LOGIC_OP_PIPE_STATS_EN
  logic [15:0] out_count;
`endif

  logic_op_pipe_if #(.WIDTH(W)) bus ();

  logic_op_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef LOGIC_OP_PIPE_STATS_EN
    ,
    .out_count (out_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int pop_total = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled, 3: one-cycle pulse then stalled

  // Reference model: an open accumulate sequence is just the list of its terms.
  bit           seq_on = 0;
  bit           seq_or = 0;
  logic [W-1:0] seq_terms[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fold_terms(input bit is_or);
    logic [W-1:0] r;
    r = is_or ? '0 : '1;
    foreach (seq_terms[i]) r = is_or ? (r | seq_terms[i]) : (r & seq_terms[i]);
    return r;
  endfunction

  function automatic void model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] op, input logic last);
    logic [W-1:0] t;
    if (seq_on) begin
      t = seq_or ? (a | b) : (a & b);
      seq_terms.push_back(t);
      if (last) begin
        exp_q.push_back(fold_terms(seq_or));
        seq_terms.delete();
        seq_on = 0;
      end
    end else begin
      case (op)
        3'd0: exp_q.push_back(a & b);
        3'd1: exp_q.push_back(a | b);
        3'd2: exp_q.push_back(a ^ b);
        3'd3: exp_q.push_back(~(a & b));
        3'd4: exp_q.push_back(~(a | b));
        3'd5: exp_q.push_back(~(a ^ b));
        default: begin
          t = (op == 3'd7) ? (a | b) : (a & b);
          if (last) exp_q.push_back(t);
          else begin
            seq_on = 1;
            seq_or = (op == 3'd7);
            seq_terms.delete();
            seq_terms.push_back(t);
          end
        end
      endcase
    end
  endfunction

  // ---------------- consumer / monitor ----------------
  bit           hold_pend = 0;
  logic [W-1:0] hold_y;

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        3: begin bus.out_ready = 1'b1; rdy_mode = 2; end
        default: bus.out_ready = 1'b0;
      endcase
      #1;
      if (!rst_n) hold_pend = 0;
      else begin
        if (hold_pend) begin
          check_val("hold_valid", bus.out_valid, 1);
          check_val("hold_y", bus.out_y, hold_y);
        end
        hold_pend = 0;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check_val("spurious_pop", 1, 0);
          else begin
            e = exp_q.pop_front();
            check_val("out_y", bus.out_y, e);
            check_val("out_red", bus.out_red, &e);
            pop_total++;
          end
        end else if (bus.out_valid) begin
          hold_pend = 1;
          hold_y    = bus.out_y;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic last);
    int  waited = 0;
    bit  done = 0;
    while (!done) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      bus.in_last  = last;
      #1;
      if (bus.in_ready) begin
        model_beat(a, b, op, last);
        done = 1;
      end else if (++waited > 200) begin
        check_val("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    check_val("busy", busy, seq_on);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    idle(1);
    rdy_mode = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 500) begin
      @(negedge clk);
      #2;
      k++;
    end
    check_val("drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] tbl [6];
  logic [2:0]   rop;

  initial begin
    tbl = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_y", bus.out_y, 0);
    check_val("rst_out_red", bus.out_red, 0);
    check_val("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ops 0-5, one result per cycle, visible one cycle after acceptance.
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      send_beat(8'hF0, 8'h3C, 3'(i), 1'b0);
      check_val("op_valid", bus.out_valid, 1);
      check_val("op_y", bus.out_y, tbl[i]);
    end
    drain();
    check_val("empty_hold_y", bus.out_y, 8'h33);

    // ACC_AND over three beats.
    send_beat(8'hFF, 8'hFE, 3'd6, 1'b0);
    check_val("acc_no_early", bus.out_valid, 0);
    send_beat(8'hFF, 8'h7F, 3'd2, 1'b0);
    send_beat(8'hF0, 8'hFF, 3'd0, 1'b1);
    check_val("acc_and_y", bus.out_y, 8'h70);
    check_val("acc_and_red", bus.out_red, 0);
    drain();

    // ACC_OR closed on its first beat.
    send_beat(8'h81, 8'h00, 3'd7, 1'b1);
    check_val("acc_or_y", bus.out_y, 8'h81);
    drain();

    // Full FIFO: third beat waits until one pop frees a slot.
    rdy_mode = 2;
    send_beat(8'h11, 8'hFF, 3'd0, 1'b0);
    send_beat(8'h22, 8'hFF, 3'd0, 1'b0);
    @(negedge clk); #1;
    check_val("full_in_ready", bus.in_ready, 0);
    fork
      send_beat(8'h33, 8'hFF, 3'd0, 1'b0);
    join_none
    @(posedge clk); #1;
    rdy_mode = 3;
    @(posedge clk); #1;
    check_val("after_pop_count_in_ready", bus.in_ready, 1);
    @(negedge clk); #1;
    check_val("after_pop_in_ready", bus.in_ready, 1);
    wait fork;
    check_val("refill_in_ready", bus.in_ready, 0);
    drain();

    // Reset in the middle of an accumulate sequence.
    send_beat(8'hFF, 8'h0F, 3'd6, 1'b0);
    send_beat(8'hF0, 8'hFF, 3'd6, 1'b0);
    check_val("mid_busy", busy, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_out_valid", bus.out_valid, 0);
    check_val("mid_rst_in_ready", bus.in_ready, 1);
    seq_on = 0; seq_terms.delete(); pop_total = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("post_rst_quiet", bus.out_valid, 0);
    send_beat(8'h0F, 8'h3C, 3'd7, 1'b0);
    send_beat(8'h40, 8'h00, 3'd7, 1'b1);
    check_val("post_rst_seq", bus.out_y, 8'h7F);
    drain();

    // Random traffic with random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      send_beat(W'($urandom), W'($urandom), rop, ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    if (seq_on) send_beat(W'($urandom), W'($urandom), 3'd0, 1'b1);
    drain();

`ifdef LOGIC_OP_PIPE_STATS_EN
    check_val("stat_count", out_count, pop_total);
    for (int i = 0; i < 5; i++) send_beat(W'(i), 8'hFF, 3'd0, 1'b0);
    drain();
    check_val("stat_count5", out_count, pop_total);
    for (int i = 0; i < 65540; i++) send_beat(W'(i), 8'hFF, 3'd1, 1'b0);
    drain();
    check_val("stat_sat", out_count, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
